// File: rtl/vac_seq_pkg.sv
//------------------------------------------------------------------------------
// vac_seq_pkg
// Shared definitions for the stepped-frequency sweep sequencer:
//   - default datapath widths
//   - FSM state encoding
//   - small state-decode helpers used by the top-level output logic
//------------------------------------------------------------------------------
package vac_seq_pkg;

    localparam int DEF_FTW_W   = 32;  // tuning word / phase accumulator width
    localparam int DEF_PHASE_W = 12;  // output phase width (accumulator MSBs)
    localparam int DEF_AMP_W   = 10;  // amplitude word width
    localparam int DEF_CNT_W   = 16;  // dwell counter width
    localparam int DEF_STEP_W  = 16;  // step index width

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        NEXT = 3'd3,
        DONE = 3'd4
    } state_t;

    // Sweep is in progress (configuration is frozen).
    function automatic logic state_is_busy(input state_t s);
        return (s == LOAD) || (s == RUN) || (s == NEXT);
    endfunction

    // Accumulator is stepping and the phase/amplitude outputs are meaningful.
    function automatic logic state_is_active(input state_t s);
        return (s == RUN) || (s == NEXT);
    endfunction

endpackage : vac_seq_pkg

// File: rtl/vac_phase_acc.sv
//------------------------------------------------------------------------------
// vac_phase_acc
// Phase accumulator for the sweep datapath. Adds the current tuning word every
// enabled cycle (wrapping modulo 2^FTW_W) and presents the top PHASE_W bits
// plus a constant phase offset (modulo 2^PHASE_W).
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (clears accumulator)
//   clr        in   synchronous clear, has priority over en
//   en         in   accumulate ftw this cycle
//   ftw        in   FTW_W   tuning word to add
//   phase_off  in   PHASE_W constant phase offset
//   phase      out  PHASE_W acc[FTW_W-1 -: PHASE_W] + phase_off
//------------------------------------------------------------------------------
module vac_phase_acc
    import vac_seq_pkg::*;
#(
    parameter int FTW_W   = DEF_FTW_W,
    parameter int PHASE_W = DEF_PHASE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic [FTW_W-1:0]   ftw,
    input  logic [PHASE_W-1:0] phase_off,
    output logic [PHASE_W-1:0] phase
);

    logic [FTW_W-1:0] acc_reg;
    logic [FTW_W-1:0] acc_next;

    // Natural binary overflow gives the modulo-2^FTW_W wrap for free.
    always_comb begin
        acc_next = acc_reg;
        if (clr) begin
            acc_next = '0;
        end else if (en) begin
            acc_next = acc_reg + ftw;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_next;
        end
    end

    // Truncate to the phase MSBs, then offset; the add wraps at PHASE_W bits.
    assign phase = acc_reg[FTW_W-1 -: PHASE_W] + phase_off;

endmodule : vac_phase_acc

// File: rtl/vac_sweep_sequencer.sv
//------------------------------------------------------------------------------
// vac_sweep_sequencer
// Drives a digital AC-source datapath through a stepped-frequency sweep.
// Each step holds its tuning word for a programmable dwell, then the word is
// advanced by a fixed increment. The phase accumulator is never cleared between
// steps, so the generated waveform stays phase-continuous across the sweep.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a sweep (only looked at in IDLE)
//   abort      in   stop the sweep from any state, highest priority
//   f_start    in   FTW_W   tuning word of the first step
//   f_step     in   FTW_W   tuning-word increment per step (wraps)
//   n_steps    in   STEP_W  number of steps, 0 = empty sweep
//   dwell      in   CNT_W   cycles per step, 0 behaves as 1
//   amp        in   AMP_W   amplitude for the whole sweep
//   phase_off  in   PHASE_W constant phase offset
//   busy       out  high in LOAD/RUN/NEXT
//   done       out  single-cycle pulse on normal completion
//   out_valid  out  phase_out/amp_out meaningful (RUN/NEXT)
//   phase_out  out  PHASE_W accumulator MSBs + phase offset
//   amp_out    out  AMP_W   latched amplitude while out_valid, else 0
//   ftw_out    out  FTW_W   current tuning word
//   step_idx   out  STEP_W  current 0-based step index
//
// Timing: a step that is followed by another lasts dwell RUN cycles plus one
// NEXT cycle; the final step lasts dwell RUN cycles and is followed by DONE.
//------------------------------------------------------------------------------
module vac_sweep_sequencer
    import vac_seq_pkg::*;
#(
    parameter int FTW_W   = DEF_FTW_W,
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int AMP_W   = DEF_AMP_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int STEP_W  = DEF_STEP_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [FTW_W-1:0]   f_start,
    input  logic [FTW_W-1:0]   f_step,
    input  logic [STEP_W-1:0]  n_steps,
    input  logic [CNT_W-1:0]   dwell,
    input  logic [AMP_W-1:0]   amp,
    input  logic [PHASE_W-1:0] phase_off,
    output logic               busy,
    output logic               done,
    output logic               out_valid,
    output logic [PHASE_W-1:0] phase_out,
    output logic [AMP_W-1:0]   amp_out,
    output logic [FTW_W-1:0]   ftw_out,
    output logic [STEP_W-1:0]  step_idx
);

    //--------------------------------------------------------------------------
    // Declarations
    //--------------------------------------------------------------------------
    state_t             state_reg;
    state_t             state_next;

    // Configuration captured when a sweep is accepted.
    logic [FTW_W-1:0]   f_start_reg;
    logic [FTW_W-1:0]   f_step_reg;
    logic [STEP_W-1:0]  n_steps_reg;
    logic [CNT_W-1:0]   dwell_reg;       // already clamped to >= 1
    logic [AMP_W-1:0]   amp_reg;
    logic [PHASE_W-1:0] phase_off_reg;

    // Sweep progress.
    logic [FTW_W-1:0]   ftw_reg;
    logic [FTW_W-1:0]   ftw_next;
    logic [STEP_W-1:0]  idx_reg;
    logic [STEP_W-1:0]  idx_next;
    logic [CNT_W-1:0]   dwell_cnt_reg;
    logic [CNT_W-1:0]   dwell_cnt_next;

    logic               accept_start;
    logic               dwell_last;
    logic               step_last;
    logic               acc_clr;
    logic               acc_en;

    //--------------------------------------------------------------------------
    // Decode helpers
    //--------------------------------------------------------------------------
    assign accept_start = (state_reg == IDLE) && start && !abort;
    assign dwell_last   = (dwell_cnt_reg == CNT_W'(1));
    // Only evaluated in RUN, where n_steps_reg is known to be non-zero.
    assign step_last    = (idx_reg == (n_steps_reg - STEP_W'(1)));

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_next = LOAD;
                    end
                end
                LOAD: begin
                    state_next = (n_steps_reg == '0) ? DONE : RUN;
                end
                RUN: begin
                    if (dwell_last) begin
                        state_next = step_last ? DONE : NEXT;
                    end
                end
                NEXT:    state_next = RUN;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // FSM: outputs (Moore, decoded from the registered state)
    //--------------------------------------------------------------------------
    always_comb begin
        busy      = state_is_busy(state_reg);
        out_valid = state_is_active(state_reg);
        done      = (state_reg == DONE);
    end

    //--------------------------------------------------------------------------
    // Configuration capture. Inputs are only sampled on an accepted start, so
    // anything that changes while the sweep runs has no effect.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_start_reg   <= '0;
            f_step_reg    <= '0;
            n_steps_reg   <= '0;
            dwell_reg     <= '0;
            amp_reg       <= '0;
            phase_off_reg <= '0;
        end else if (accept_start) begin
            f_start_reg   <= f_start;
            f_step_reg    <= f_step;
            n_steps_reg   <= n_steps;
            dwell_reg     <= (dwell == '0) ? CNT_W'(1) : dwell;
            amp_reg       <= amp;
            phase_off_reg <= phase_off;
        end
    end

    //--------------------------------------------------------------------------
    // Step sequencing: tuning word, step index, dwell counter.
    // Abort freezes these; ftw_out/step_idx keep their last values in IDLE.
    //--------------------------------------------------------------------------
    always_comb begin
        ftw_next       = ftw_reg;
        idx_next       = idx_reg;
        dwell_cnt_next = dwell_cnt_reg;
        if (!abort) begin
            case (state_reg)
                LOAD: begin
                    ftw_next       = f_start_reg;
                    idx_next       = '0;
                    dwell_cnt_next = dwell_reg;
                end
                RUN: begin
                    dwell_cnt_next = dwell_cnt_reg - CNT_W'(1);
                end
                NEXT: begin
                    // Wraps on overflow; sweeps past full scale fold around.
                    ftw_next       = ftw_reg + f_step_reg;
                    idx_next       = idx_reg + STEP_W'(1);
                    dwell_cnt_next = dwell_reg;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ftw_reg       <= '0;
            idx_reg       <= '0;
            dwell_cnt_reg <= '0;
        end else begin
            ftw_reg       <= ftw_next;
            idx_reg       <= idx_next;
            dwell_cnt_reg <= dwell_cnt_next;
        end
    end

    //--------------------------------------------------------------------------
    // Phase accumulator. Cleared only at the start of a sweep or on abort, so
    // step changes never introduce a phase discontinuity. NEXT still
    // accumulates with the outgoing tuning word.
    //--------------------------------------------------------------------------
    assign acc_clr = abort || (state_reg == LOAD);
    assign acc_en  = state_is_active(state_reg);

    vac_phase_acc #(
        .FTW_W   (FTW_W),
        .PHASE_W (PHASE_W)
    ) u_phase_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (acc_clr),
        .en        (acc_en),
        .ftw       (ftw_reg),
        .phase_off (phase_off_reg),
        .phase     (phase_out)
    );

    //--------------------------------------------------------------------------
    // Output drive. Amplitude is forced to zero whenever the output is not
    // valid so the DAC path is silent outside an active sweep.
    //--------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < AMP_W; gi++) begin : g_amp_gate
            assign amp_out[gi] = amp_reg[gi] & out_valid;
        end
    endgenerate

    assign ftw_out  = ftw_reg;
    assign step_idx = idx_reg;

endmodule : vac_sweep_sequencer

// File: tb/tb_vac_sweep_sequencer.sv
//------------------------------------------------------------------------------
// tb_vac_sweep_sequencer
// Scoreboard bench: each launched sweep pushes its expected output cycles into
// a queue; an independent monitor pops and compares whenever the DUT shows
// out_valid or done. Directed checks cover reset, latency, abort and holds.
//------------------------------------------------------------------------------
module tb_vac_sweep_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] f_start;
    logic [31:0] f_step;
    logic [15:0] n_steps;
    logic [15:0] dwell;
    logic [9:0]  amp;
    logic [11:0] phase_off;
    logic        busy;
    logic        done;
    logic        out_valid;
    logic [11:0] phase_out;
    logic [9:0]  amp_out;
    logic [31:0] ftw_out;
    logic [15:0] step_idx;

    always #5 clk = ~clk;

    vac_sweep_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .f_start   (f_start),
        .f_step    (f_step),
        .n_steps   (n_steps),
        .dwell     (dwell),
        .amp       (amp),
        .phase_off (phase_off),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .phase_out (phase_out),
        .amp_out   (amp_out),
        .ftw_out   (ftw_out),
        .step_idx  (step_idx)
    );

    typedef struct packed {
        logic        is_done;
        logic [11:0] phase;
        logic [9:0]  amp;
        logic [31:0] ftw;
        logic [15:0] idx;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          valid_cnt = 0;
    int          done_cnt = 0;
    int          txn = 0;
    logic [31:0] last_ftw = '0;
    logic [15:0] last_idx = '0;
    exp_t        e_mon;
    logic        ok_mon;

    //--------------------------------------------------------------------------
    // Monitor / scoreboard
    //--------------------------------------------------------------------------
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (out_valid === 1'b1 || done === 1'b1)) begin
            if (out_valid) begin
                valid_cnt++;
                last_ftw = ftw_out;
                last_idx = step_idx;
            end
            if (done) done_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output txn %0d: got valid=%0b done=%0b phase=%h ftw=%h idx=%0d, required no output",
                         txn, out_valid, done, phase_out, ftw_out, step_idx);
            end else begin
                e_mon = exp_q.pop_front();
                if (e_mon.is_done)
                    ok_mon = done && !out_valid && !busy && (amp_out == '0);
                else
                    ok_mon = out_valid && !done && busy && (phase_out == e_mon.phase) &&
                             (amp_out == e_mon.amp) && (ftw_out == e_mon.ftw) && (step_idx == e_mon.idx);
                if (!ok_mon) begin
                    bad++;
                    $display("FAIL scoreboard txn %0d: got valid=%0b done=%0b busy=%0b phase=%h amp=%h ftw=%h idx=%0d, required done=%0b phase=%h amp=%h ftw=%h idx=%0d",
                             txn, out_valid, done, busy, phase_out, amp_out, ftw_out, step_idx,
                             e_mon.is_done, e_mon.phase, e_mon.amp, e_mon.ftw, e_mon.idx);
                end else begin
                    $display("txn %0d: done=%0b phase=%h amp=%h ftw=%h idx=%0d",
                             txn, done, phase_out, amp_out, ftw_out, step_idx);
                end
            end
            txn++;
        end
    end

    //--------------------------------------------------------------------------
    // Helpers
    //--------------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Expected output stream of one sweep: step k holds f_start + k*f_step for
    // dwell cycles, plus a NEXT cycle unless it is the last step.
    task automatic push_sweep(input logic [31:0] fs, input logic [31:0] fst,
                              input logic [15:0] ns, input logic [15:0] dw,
                              input logic [9:0] am, input logic [11:0] po,
                              input int limit, input bit with_done);
        logic [31:0] acc;
        logic [31:0] ftw;
        exp_t        e;
        int          d;
        int          cyc;
        int          cnt;
        acc = '0;
        ftw = fs;
        cnt = 0;
        d   = (dw == 16'd0) ? 1 : int'(dw);
        for (int k = 0; k < int'(ns); k++) begin
            cyc = (k == int'(ns) - 1) ? d : d + 1;
            for (int c = 0; c < cyc; c++) begin
                if (cnt < limit) begin
                    e.is_done = 1'b0;
                    e.phase   = acc[31:20] + po;
                    e.amp     = am;
                    e.ftw     = ftw;
                    e.idx     = 16'(k);
                    exp_q.push_back(e);
                end
                cnt++;
                acc = acc + ftw;
            end
            ftw = ftw + fst;
        end
        if (with_done) begin
            e = '0;
            e.is_done = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    // Called at a negedge; leaves the bench at the following negedge (LOAD).
    task automatic launch(input logic [31:0] fs, input logic [31:0] fst,
                          input logic [15:0] ns, input logic [15:0] dw,
                          input logic [9:0] am, input logic [11:0] po);
        f_start   = fs;
        f_step    = fst;
        n_steps   = ns;
        dwell     = dw;
        amp       = am;
        phase_off = po;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL %s: got no done within 300 cycles, required done pulse", name);
        end
        @(negedge clk);
    endtask

    task automatic clear_counts();
        valid_cnt = 0;
        done_cnt  = 0;
    endtask

    //--------------------------------------------------------------------------
    // Stimulus
    //--------------------------------------------------------------------------
    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        f_start = '0; f_step = '0; n_steps = '0; dwell = '0; amp = '0; phase_off = '0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_phase_out", 32'(phase_out), 32'd0);
        check("rst_amp_out",   32'(amp_out),   32'd0);
        check("rst_ftw_out",   ftw_out,        32'd0);
        check("rst_step_idx",  32'(step_idx),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic 3-step sweep, with a restart attempt and config churn mid-sweep.
        clear_counts();
        push_sweep(32'h1000_0000, 32'h0100_0000, 16'd3, 16'd4, 10'h155, 12'h005, 1000, 1'b1);
        launch(32'h1000_0000, 32'h0100_0000, 16'd3, 16'd4, 10'h155, 12'h005);
        check("t1_busy_in_load",  32'(busy),      32'd1);
        check("t1_valid_in_load", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t1_first_valid",   32'(out_valid), 32'd1);
        check("t1_first_phase",   32'(phase_out), 32'h005);
        start = 1'b1; f_start = 32'hDEAD_BEEF; f_step = 32'h1; n_steps = 16'd7;
        dwell = 16'd1; amp = 10'h000; phase_off = 12'h7FF;
        @(negedge clk);
        start = 1'b0;
        wait_done("t1_done");
        check("t1_valid_cnt", 32'(valid_cnt), 32'd14);
        check("t1_done_cnt",  32'(done_cnt),  32'd1);
        check("t1_last_ftw",  last_ftw,       32'h1200_0000);
        check("t1_last_idx",  32'(last_idx),  32'd2);
        check("t1_hold_ftw",  ftw_out,        32'h1200_0000);
        check("t1_hold_idx",  32'(step_idx),  32'd2);
        check("t1_idle_busy", 32'(busy),      32'd0);
        check("t1_q_empty",   32'(exp_q.size()), 32'd0);

        // Empty sweep: LOAD then DONE, never valid.
        clear_counts();
        push_sweep(32'h0200_0000, 32'h0, 16'd0, 16'd5, 10'h0AA, 12'h010, 1000, 1'b1);
        launch(32'h0200_0000, 32'h0, 16'd0, 16'd5, 10'h0AA, 12'h010);
        check("t2_done_early", 32'(done), 32'd0);
        @(negedge clk);
        check("t2_done_pulse", 32'(done),      32'd1);
        check("t2_no_valid",   32'(out_valid), 32'd0);
        @(negedge clk);
        check("t2_done_len",   32'(done),      32'd0);
        check("t2_valid_cnt",  32'(valid_cnt), 32'd0);
        check("t2_q_empty",    32'(exp_q.size()), 32'd0);

        // dwell = 0 behaves as dwell = 1.
        clear_counts();
        push_sweep(32'h0400_0000, 32'h0400_0000, 16'd2, 16'd0, 10'h2F0, 12'h100, 1000, 1'b1);
        launch(32'h0400_0000, 32'h0400_0000, 16'd2, 16'd0, 10'h2F0, 12'h100);
        wait_done("t3_done");
        check("t3_valid_cnt", 32'(valid_cnt), 32'd3);
        check("t3_last_idx",  32'(last_idx),  32'd1);
        check("t3_q_empty",   32'(exp_q.size()), 32'd0);

        // Tuning-word and accumulator wrap.
        clear_counts();
        push_sweep(32'hFFFF_FFF0, 32'h0000_0020, 16'd2, 16'd3, 10'h3FF, 12'hABC, 1000, 1'b1);
        launch(32'hFFFF_FFF0, 32'h0000_0020, 16'd2, 16'd3, 10'h3FF, 12'hABC);
        wait_done("t4_done");
        check("t4_valid_cnt", 32'(valid_cnt), 32'd7);
        check("t4_wrap_ftw",  last_ftw,       32'h0000_0010);
        check("t4_q_empty",   32'(exp_q.size()), 32'd0);

        // Abort during the fifth valid cycle, then a clean restart.
        clear_counts();
        push_sweep(32'h1000_0000, 32'h0100_0000, 16'd3, 16'd4, 10'h155, 12'h005, 5, 1'b0);
        launch(32'h1000_0000, 32'h0100_0000, 16'd3, 16'd4, 10'h155, 12'h005);
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_abort_busy",  32'(busy),      32'd0);
        check("t5_abort_valid", 32'(out_valid), 32'd0);
        check("t5_abort_amp",   32'(amp_out),   32'd0);
        check("t5_abort_phase", 32'(phase_out), 32'h005);
        repeat (3) @(negedge clk);
        check("t5_no_done",     32'(done_cnt),  32'd0);
        check("t5_valid_cnt",   32'(valid_cnt), 32'd5);
        check("t5_q_empty",     32'(exp_q.size()), 32'd0);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("t5_abort_wins",  32'(busy),      32'd0);
        clear_counts();
        push_sweep(32'h1000_0000, 32'h0100_0000, 16'd3, 16'd4, 10'h155, 12'h005, 1000, 1'b1);
        launch(32'h1000_0000, 32'h0100_0000, 16'd3, 16'd4, 10'h155, 12'h005);
        wait_done("t5_restart_done");
        check("t5_restart_cnt", 32'(valid_cnt), 32'd14);
        check("t5_restart_q",   32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of RUN.
        clear_counts();
        push_sweep(32'h0800_0000, 32'h0080_0000, 16'd2, 16'd6, 10'h1C3, 12'h020, 3, 1'b0);
        launch(32'h0800_0000, 32'h0080_0000, 16'd2, 16'd6, 10'h1C3, 12'h020);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_busy",  32'(busy),      32'd0);
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_phase", 32'(phase_out), 32'd0);
        check("t6_rst_amp",   32'(amp_out),   32'd0);
        check("t6_rst_ftw",   ftw_out,        32'd0);
        check("t6_rst_idx",   32'(step_idx),  32'd0);
        check("t6_rst_done",  32'(done),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_no_done",   32'(done_cnt),  32'd0);
        check("t6_valid_cnt", 32'(valid_cnt), 32'd3);
        check("t6_q_empty",   32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_vac_sweep_sequencer
